pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC and all inter-stage registers (IF/ID … MEM/WB).
- Sequences multi-cycle EX operations (divide) and bounds memory-wait stalls with a timeout.
- Raises flush and the redirect PC on exceptions.

Parameters:
- MULTI_CYCLES, 32, total EX stall cycles for a multi-cycle operation; must be >= 2.
- MEM_TIMEOUT, 16, consecutive memory-wait cycles before bus error; must be >= 2.
- EXC_VECTOR, 32'h0000_0020, redirect PC on exception or bus error.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_request_if  in  1  IF stage needs hold.
- stall_request_id  in  1  ID stage needs hold (load-use hazard).
- stall_request_ex  in  1  EX stage generic hold.
- ex_multicycle_start  in  1  EX issues a multi-cycle op this cycle.
- ex_multicycle_done  out  1  one-cycle pulse: result valid, EX may advance.
- mem_request  in  1  MEM stage has a bus access.
- mem_ready  in  1  bus completes the access this cycle.
- exception_valid  in  1  exception committed in MEM.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid when flush=1; otherwise 0.
- bus_error  out  1  one-cycle pulse on memory timeout.
- stall_cycle_count  out  32  perf counter; see Optional Feature.

Behaviour:
- Reset: asynchronous and active-high. While asserted, state=IDLE, multi counter=0, wait counter=0, and all outputs are 0.
- State register: IDLE, MULTI. Counters: mc_cnt (clog2(MULTI_CYCLES) bits) and wait_cnt (clog2(MEM_TIMEOUT) bits).
- mem_wait = mem_request && !mem_ready.
- ex_hold = stall_request_ex || (IDLE && ex_multicycle_start) || (MULTI && mc_cnt != 0).
- Stall vector is combinational. The deepest stalled stage wins:
  - mem_wait -> 6'b011111
  - else ex_hold -> 6'b001111
  - else stall_request_id -> 6'b000111
  - else stall_request_if -> 6'b000011
  - else 6'b000000
- Stall bit 5 is never set. A stalled MEM with free-running WB inserts a WB bubble.
- Flush conditions: flush=1 when exception_valid=1, or when a timeout fires. While flush=1, stall=0 and new_pc=EXC_VECTOR.
- IDLE -> MULTI: on ex_multicycle_start with no flush that cycle; mc_cnt <= MULTI_CYCLES-1.
- ex_multicycle_start in MULTI is ignored.
- MULTI countdown:
  - mc_cnt decrements only when mem_wait=0; it freezes while MEM waits.
  - When mc_cnt==0 and mem_wait=0: ex_multicycle_done=1, EX stall released, next state IDLE.
  - Result: exactly MULTI_CYCLES EX-stall cycles (start cycle included), with done in cycle MULTI_CYCLES after start, absent MEM waits.
- Timeout:
  - wait_cnt increments each mem_wait cycle and clears on any non-wait cycle.
  - When mem_wait && wait_cnt==MEM_TIMEOUT-1: bus_error=1 and flush=1 that cycle, and wait_cnt clears.
- mem_request && mem_ready in the same cycle: no stall, wait_cnt cleared.
- Flush in MULTI aborts the operation: state IDLE, mc_cnt=0, no done pulse.
- Flush has priority over start in the same cycle, so the operation is not started.
- Reset asserted mid-MULTI returns to IDLE immediately; no done pulse.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_COUNTER_EN.
- When defined: a 32-bit counter increments on every cycle with stall != 0. It wraps 32'hFFFF_FFFF -> 0, resets to 0, is not cleared by flush, and drives stall_cycle_count.
- When undefined: no counter logic; stall_cycle_count tied to 0.

Decomposition:
- Shared defines/package holds:
  - STALL_ENABLE / STALL_DISABLE and RESET_ENABLE
  - stall-vector constants STALL_NONE, STALL_FROM_IF, STALL_FROM_ID, STALL_FROM_EX, STALL_FROM_MEM
  - the IDLE/MULTI state encoding
  - EXC_VECTOR default
- One natural sub-module, mem_wait_timer: holds wait_cnt and the timeout compare, and outputs the timeout pulse.

Test Plan:
- Reset: assert reset mid-MULTI -> all outputs 0 asynchronously; after release no ex_multicycle_done pulse ever appears.
- Priority: stall_request_if=1, stall_request_id=1, all others 0 -> stall=000111. Then add mem_request=1, mem_ready=0 -> stall=011111.
- Multi-cycle with MULTI_CYCLES=4: start pulse at t0 -> stall=001111 at t0..t3; ex_multicycle_done=1 and stall=0 at t4.
- Freeze: as above with mem_wait for 2 cycles at t2 -> done moves to t6; stall=011111 during the wait.
- Timeout with MEM_TIMEOUT=16: mem_request=1, mem_ready=0 held -> cycles 0–14 stall=011111; cycle 15 bus_error=1, flush=1, stall=0, new_pc=32'h20. mem_ready at cycle 10 instead -> no bus_error.
- Exception in MULTI: exception_valid at t2 -> flush=1, stall=0, new_pc=EXC_VECTOR; state IDLE; no done pulse. With the perf macro, stall_cycle_count equals 2.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared constants for the 5-stage MIPS pipeline stall/flush controller:
//   - stall/reset polarity constants
//   - stall-vector encodings (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB)
//   - IDLE/MULTI state encoding
//   - default exception redirect vector
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic RESET_ENABLE  = 1'b1;

    // A stall at a given stage also holds every stage upstream of it.
    // WB is never held: a stalled MEM simply hands WB a bubble.
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
    localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_mem_wait_timer
// Counts consecutive memory-wait cycles and fires a one-cycle timeout pulse on
// the MEM_TIMEOUT-th consecutive wait cycle. The count clears on any cycle
// without a wait and on the timeout cycle itself.
// Ports:
//   clock    in  system clock, rising edge
//   reset    in  asynchronous, active-high
//   mem_wait in  MEM stage is waiting on the bus this cycle
//   timeout  out one-cycle pulse: wait limit reached
// -----------------------------------------------------------------------------
module pipeline_ctrl_mem_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_wait,
    output logic timeout
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [WC_W-1:0] wait_cnt_r;
    logic            timeout_s;

    // Timeout compare; suppressed while reset is held so every output is 0.
    always_comb begin
        timeout_s = 1'b0;
        if ((reset != RESET_ENABLE) && mem_wait && (wait_cnt_r == WC_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Consecutive-wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if (!mem_wait || timeout_s) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + {{(WC_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout = timeout_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the 5-stage MIPS pipeline.
//   - merges per-stage stall requests into a 6-bit stall vector (deepest wins)
//   - sequences multi-cycle EX operations (divide) with a countdown
//   - bounds memory waits with a timeout that raises bus_error + flush
//   - raises flush and the redirect PC on exceptions
// Ports:
//   clock, reset (async active-high)
//   stall_request_if/id/ex   per-stage hold requests
//   ex_multicycle_start      EX issues a multi-cycle op this cycle
//   ex_multicycle_done       one-cycle pulse: multi-cycle result valid
//   mem_request, mem_ready   MEM bus handshake
//   exception_valid          exception committed in MEM
//   stall[5:0]               bit0 PC .. bit5 WB, 1 = hold (combinational)
//   flush, new_pc            pipeline flush and redirect target
//   bus_error                one-cycle pulse on memory timeout
//   stall_cycle_count        stalled-cycle perf counter
// Optional feature macro: PIPELINE_CTRL_PERF_COUNTER_EN enables the 32-bit
// stalled-cycle counter; without it stall_cycle_count is tied to 0.
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          MULTI_CYCLES = 32,
    parameter int          MEM_TIMEOUT  = 16,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_request_if,
    input  logic        stall_request_id,
    input  logic        stall_request_ex,
    input  logic        ex_multicycle_start,
    output logic        ex_multicycle_done,
    input  logic        mem_request,
    input  logic        mem_ready,
    input  logic        exception_valid,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_error,
    output logic [31:0] stall_cycle_count
);

    localparam int MC_W = $clog2(MULTI_CYCLES);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MULTI_CYCLES - 1);
    localparam logic [MC_W-1:0] MC_ZERO = {MC_W{1'b0}};

    state_e          state_r;
    state_e          state_n_s;
    logic [MC_W-1:0] mc_cnt_r;
    logic [MC_W-1:0] mc_cnt_n_s;

    logic            mem_wait_s;
    logic            timeout_s;
    logic            flush_s;
    logic            ex_hold_s;
    logic            done_s;
    logic [5:0]      stall_s;
    logic [31:0]     new_pc_s;

    assign mem_wait_s = mem_request && !mem_ready;

    pipeline_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .mem_wait (mem_wait_s),
        .timeout  (timeout_s)
    );

    // Hazard/flush qualifiers; reset forces every output low.
    always_comb begin
        flush_s   = 1'b0;
        ex_hold_s = 1'b0;
        done_s    = 1'b0;
        if (reset == RESET_ENABLE) begin
            flush_s   = 1'b0;
            ex_hold_s = 1'b0;
            done_s    = 1'b0;
        end else begin
            flush_s   = exception_valid || timeout_s;
            ex_hold_s = stall_request_ex
                     || ((state_r == ST_IDLE)  && ex_multicycle_start)
                     || ((state_r == ST_MULTI) && (mc_cnt_r != MC_ZERO));
            // A flush aborts the op, so the final countdown cycle never reports done.
            done_s    = (state_r == ST_MULTI) && (mc_cnt_r == MC_ZERO)
                     && !mem_wait_s && !flush_s;
        end
    end

    // Stall vector: deepest stalled stage wins; a flush cycle never stalls.
    always_comb begin
        stall_s = STALL_NONE;
        if ((reset == RESET_ENABLE) || flush_s) begin
            stall_s = STALL_NONE;
        end else if (mem_wait_s) begin
            stall_s = STALL_FROM_MEM;
        end else if (ex_hold_s) begin
            stall_s = STALL_FROM_EX;
        end else if (stall_request_id == STALL_ENABLE) begin
            stall_s = STALL_FROM_ID;
        end else if (stall_request_if == STALL_ENABLE) begin
            stall_s = STALL_FROM_IF;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    // Redirect target is only meaningful during a flush.
    always_comb begin
        new_pc_s = 32'h0000_0000;
        if (flush_s) begin
            new_pc_s = EXC_VECTOR;
        end else begin
            new_pc_s = 32'h0000_0000;
        end
    end

    // Multi-cycle sequencer next state; flush beats start and aborts MULTI.
    always_comb begin
        state_n_s  = state_r;
        mc_cnt_n_s = mc_cnt_r;
        if (flush_s) begin
            state_n_s  = ST_IDLE;
            mc_cnt_n_s = MC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_multicycle_start) begin
                        state_n_s  = ST_MULTI;
                        mc_cnt_n_s = MC_LOAD;
                    end else begin
                        state_n_s  = ST_IDLE;
                        mc_cnt_n_s = mc_cnt_r;
                    end
                end
                ST_MULTI: begin
                    // Countdown freezes while MEM waits so EX cannot retire early.
                    if (mem_wait_s) begin
                        state_n_s  = ST_MULTI;
                        mc_cnt_n_s = mc_cnt_r;
                    end else if (mc_cnt_r == MC_ZERO) begin
                        state_n_s  = ST_IDLE;
                        mc_cnt_n_s = MC_ZERO;
                    end else begin
                        state_n_s  = ST_MULTI;
                        mc_cnt_n_s = mc_cnt_r - {{(MC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_n_s  = ST_IDLE;
                    mc_cnt_n_s = MC_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and countdown registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            state_r  <= ST_IDLE;
            mc_cnt_r <= MC_ZERO;
        end else begin
            state_r  <= state_n_s;
            mc_cnt_r <= mc_cnt_n_s;
        end
    end

`ifdef PIPELINE_CTRL_PERF_COUNTER_EN
    logic [31:0] perf_cnt_r;

    // Stalled-cycle counter; wraps naturally and survives flushes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (stall_s != STALL_NONE) begin
            perf_cnt_r <= perf_cnt_r + 32'h0000_0001;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign stall_cycle_count = perf_cnt_r;
`else
    assign stall_cycle_count = 32'h0000_0000;
`endif

    assign stall              = stall_s;
    assign flush              = flush_s;
    assign new_pc             = new_pc_s;
    assign bus_error          = timeout_s;
    assign ex_multicycle_done = done_s;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed self-checking bench for pipeline_ctrl with MULTI_CYCLES=4 and
// MEM_TIMEOUT=16. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_request_if = 1'b0;
    logic        stall_request_id = 1'b0;
    logic        stall_request_ex = 1'b0;
    logic        ex_multicycle_start = 1'b0;
    logic        ex_multicycle_done;
    logic        mem_request = 1'b0;
    logic        mem_ready = 1'b0;
    logic        exception_valid = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_error;
    logic [31:0] stall_cycle_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    pipeline_ctrl #(
        .MULTI_CYCLES (4),
        .MEM_TIMEOUT  (16),
        .EXC_VECTOR   (32'h0000_0020)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .stall_request_if    (stall_request_if),
        .stall_request_id    (stall_request_id),
        .stall_request_ex    (stall_request_ex),
        .ex_multicycle_start (ex_multicycle_start),
        .ex_multicycle_done  (ex_multicycle_done),
        .mem_request         (mem_request),
        .mem_ready           (mem_ready),
        .exception_valid     (exception_valid),
        .stall               (stall),
        .flush               (flush),
        .new_pc              (new_pc),
        .bus_error           (bus_error),
        .stall_cycle_count   (stall_cycle_count)
    );

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp_stall;
        // Reset held with a pending IF request: everything must read 0.
        stall_request_if = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b000000) $display("FAIL reset_stall: got %b want 000000", stall); else pass_cnt++;
        total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else pass_cnt++;
        total_cnt++; if (new_pc !== 32'h0) $display("FAIL reset_new_pc: got %h want 0", new_pc); else pass_cnt++;
        total_cnt++; if (ex_multicycle_done !== 1'b0) $display("FAIL reset_done: got %b want 0", ex_multicycle_done); else pass_cnt++;
        total_cnt++; if (bus_error !== 1'b0) $display("FAIL reset_bus_error: got %b want 0", bus_error); else pass_cnt++;
        total_cnt++; if (stall_cycle_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", stall_cycle_count); else pass_cnt++;
        stall_request_if = 1'b0;
        next_cycle();
        reset = 1'b0;
        // Start a multi-cycle op, then reset in the middle of it.
        ex_multicycle_start = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b001111) $display("FAIL rst_multi_t0: got %b want 001111", stall); else pass_cnt++;
        next_cycle();
        ex_multicycle_start = 1'b0;
        sample();
        total_cnt++; if (stall !== 6'b001111) $display("FAIL rst_multi_t1: got %b want 001111", stall); else pass_cnt++;
        next_cycle();
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (stall !== 6'b000000) $display("FAIL async_reset_stall: got %b want 000000", stall); else pass_cnt++;
        total_cnt++; if (ex_multicycle_done !== 1'b0) $display("FAIL async_reset_done: got %b want 0", ex_multicycle_done); else pass_cnt++;
        total_cnt++; if (stall_cycle_count !== 32'h0) $display("FAIL async_reset_count: got %0d want 0", stall_cycle_count); else pass_cnt++;
        next_cycle();
        reset = 1'b0;
        exp_stall = 6'b000000;
        for (int c = 0; c < 8; c++) begin
            sample();
            total_cnt++; if (ex_multicycle_done !== 1'b0) $display("FAIL post_reset_done c%0d: got %b want 0", c, ex_multicycle_done); else pass_cnt++;
            total_cnt++; if (stall !== exp_stall) $display("FAIL post_reset_stall c%0d: got %b want %b", c, stall, exp_stall); else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_priority();
        stall_request_if = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b000011) $display("FAIL prio_if: got %b want 000011", stall); else pass_cnt++;
        next_cycle();
        stall_request_id = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b000111) $display("FAIL prio_if_id: got %b want 000111", stall); else pass_cnt++;
        next_cycle();
        stall_request_ex = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b001111) $display("FAIL prio_ex: got %b want 001111", stall); else pass_cnt++;
        next_cycle();
        stall_request_ex = 1'b0;
        mem_request = 1'b1;
        mem_ready = 1'b0;
        sample();
        total_cnt++; if (stall !== 6'b011111) $display("FAIL prio_mem: got %b want 011111", stall); else pass_cnt++;
        total_cnt++; if (new_pc !== 32'h0) $display("FAIL prio_new_pc: got %h want 0", new_pc); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b000111) $display("FAIL prio_mem_ready: got %b want 000111", stall); else pass_cnt++;
        next_cycle();
        stall_request_if = 1'b0;
        stall_request_id = 1'b0;
        mem_request = 1'b0;
        mem_ready = 1'b0;
        sample();
        total_cnt++; if (stall !== 6'b000000) $display("FAIL prio_none: got %b want 000000", stall); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_multicycle();
        logic [5:0] exp_stall;
        logic       exp_done;
        ex_multicycle_start = 1'b1;
        for (int t = 0; t < 6; t++) begin
            sample();
            exp_stall = (t < 4) ? 6'b001111 : 6'b000000;
            exp_done  = (t == 4);
            total_cnt++; if (stall !== exp_stall) $display("FAIL multi_stall t%0d: got %b want %b", t, stall, exp_stall); else pass_cnt++;
            total_cnt++; if (ex_multicycle_done !== exp_done) $display("FAIL multi_done t%0d: got %b want %b", t, ex_multicycle_done, exp_done); else pass_cnt++;
            next_cycle();
            ex_multicycle_start = 1'b0;
        end
    endtask

    task automatic test_freeze();
        logic [5:0] exp_stall;
        logic       exp_done;
        ex_multicycle_start = 1'b1;
        for (int t = 0; t < 8; t++) begin
            mem_request = (t == 2 || t == 3);
            sample();
            if (t == 2 || t == 3)      exp_stall = 6'b011111;
            else if (t < 6)            exp_stall = 6'b001111;
            else                       exp_stall = 6'b000000;
            exp_done = (t == 6);
            total_cnt++; if (stall !== exp_stall) $display("FAIL freeze_stall t%0d: got %b want %b", t, stall, exp_stall); else pass_cnt++;
            total_cnt++; if (ex_multicycle_done !== exp_done) $display("FAIL freeze_done t%0d: got %b want %b", t, ex_multicycle_done, exp_done); else pass_cnt++;
            next_cycle();
            ex_multicycle_start = 1'b0;
        end
        mem_request = 1'b0;
    endtask

    task automatic test_timeout();
        logic [5:0]  exp_stall;
        logic        exp_be;
        logic [31:0] exp_pc;
        mem_request = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 17; c++) begin
            sample();
            exp_be    = (c == 15);
            exp_stall = exp_be ? 6'b000000 : 6'b011111;
            exp_pc    = exp_be ? 32'h0000_0020 : 32'h0000_0000;
            total_cnt++; if (stall !== exp_stall) $display("FAIL timeout_stall c%0d: got %b want %b", c, stall, exp_stall); else pass_cnt++;
            total_cnt++; if (bus_error !== exp_be) $display("FAIL timeout_bus_error c%0d: got %b want %b", c, bus_error, exp_be); else pass_cnt++;
            total_cnt++; if (flush !== exp_be) $display("FAIL timeout_flush c%0d: got %b want %b", c, flush, exp_be); else pass_cnt++;
            total_cnt++; if (new_pc !== exp_pc) $display("FAIL timeout_new_pc c%0d: got %h want %h", c, new_pc, exp_pc); else pass_cnt++;
            next_cycle();
        end
        mem_request = 1'b0;
        sample();
        next_cycle();
        // Ready at cycle 10 restarts the count; 15 more waits stay under the limit.
        for (int c = 0; c < 26; c++) begin
            mem_request = 1'b1;
            mem_ready   = (c == 10);
            sample();
            exp_stall = (c == 10) ? 6'b000000 : 6'b011111;
            total_cnt++; if (stall !== exp_stall) $display("FAIL ready_stall c%0d: got %b want %b", c, stall, exp_stall); else pass_cnt++;
            total_cnt++; if (bus_error !== 1'b0) $display("FAIL ready_bus_error c%0d: got %b want 0", c, bus_error); else pass_cnt++;
            next_cycle();
        end
        mem_request = 1'b0;
        mem_ready = 1'b0;
        sample();
        next_cycle();
    endtask

    task automatic test_exception();
        logic [31:0] exp_count;
        // Fresh reset so the perf counter starts from a known zero.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        ex_multicycle_start = 1'b1;
        sample();
        total_cnt++; if (stall !== 6'b001111) $display("FAIL exc_t0_stall: got %b want 001111", stall); else pass_cnt++;
        next_cycle();
        ex_multicycle_start = 1'b0;
        sample();
        total_cnt++; if (stall !== 6'b001111) $display("FAIL exc_t1_stall: got %b want 001111", stall); else pass_cnt++;
        next_cycle();
        exception_valid = 1'b1;
        sample();
        total_cnt++; if (flush !== 1'b1) $display("FAIL exc_flush: got %b want 1", flush); else pass_cnt++;
        total_cnt++; if (stall !== 6'b000000) $display("FAIL exc_stall: got %b want 000000", stall); else pass_cnt++;
        total_cnt++; if (new_pc !== 32'h0000_0020) $display("FAIL exc_new_pc: got %h want 00000020", new_pc); else pass_cnt++;
        total_cnt++; if (bus_error !== 1'b0) $display("FAIL exc_bus_error: got %b want 0", bus_error); else pass_cnt++;
        next_cycle();
        exception_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            total_cnt++; if (stall !== 6'b000000) $display("FAIL exc_after_stall c%0d: got %b want 000000", c, stall); else pass_cnt++;
            total_cnt++; if (ex_multicycle_done !== 1'b0) $display("FAIL exc_after_done c%0d: got %b want 0", c, ex_multicycle_done); else pass_cnt++;
            next_cycle();
        end
`ifdef PIPELINE_CTRL_PERF_COUNTER_EN
        exp_count = 32'd2;
`else
        exp_count = 32'd0;
`endif
        sample();
        total_cnt++; if (stall_cycle_count !== exp_count) $display("FAIL exc_count: got %0d want %0d", stall_cycle_count, exp_count); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_flush_over_start();
        exception_valid = 1'b1;
        ex_multicycle_start = 1'b1;
        sample();
        total_cnt++; if (flush !== 1'b1) $display("FAIL fos_flush: got %b want 1", flush); else pass_cnt++;
        total_cnt++; if (stall !== 6'b000000) $display("FAIL fos_stall: got %b want 000000", stall); else pass_cnt++;
        next_cycle();
        exception_valid = 1'b0;
        ex_multicycle_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            total_cnt++; if (stall !== 6'b000000) $display("FAIL fos_after_stall c%0d: got %b want 000000", c, stall); else pass_cnt++;
            total_cnt++; if (ex_multicycle_done !== 1'b0) $display("FAIL fos_after_done c%0d: got %b want 0", c, ex_multicycle_done); else pass_cnt++;
            total_cnt++; if (flush !== 1'b0) $display("FAIL fos_after_flush c%0d: got %b want 0", c, flush); else pass_cnt++;
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_multicycle();
        test_freeze();
        test_timeout();
        test_exception();
        test_flush_over_start();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
